// File: rtl/audio_dac_multi.sv
// Multi-channel 1-bit audio DAC: double-buffered frames, PWM or first-order sigma-delta per channel.
// Latency: a frame accepted in period N drives the pins in period N+1 (one extra clock from counter to pin).
// Backpressure: sample_ready drops once a frame is pending and returns the cycle after that frame moves to active.
module audio_dac_multi #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 9,
  parameter int MODE     = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] sample_in,
  input  logic                      sample_valid,
  output logic                      sample_ready,
  input  logic                      mute,
  output logic [CHANNELS-1:0]       dac_out,
  output logic                      frame_start,
  output logic [15:0]               underrun_count
);

  localparam logic [WIDTH-1:0] MIDSCALE = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};

  logic [WIDTH-1:0]                cnt_q, cnt_d;
  logic [CHANNELS-1:0][WIDTH-1:0]  pend_q, pend_d;
  logic [CHANNELS-1:0][WIDTH-1:0]  act_q, act_d;
  // Only the low WIDTH bits of each accumulator carry state; the carry is the pin value.
  logic [CHANNELS-1:0][WIDTH-1:0]  acc_q, acc_d;
  logic [CHANNELS-1:0][WIDTH:0]    sum;
  logic                            pend_full_q, pend_full_d;
  logic                            ready_q;
  logic [15:0]                     urun_q, urun_d;
  logic                            fs_q;
  logic [CHANNELS-1:0]             dac_q, dac_d;

  logic boundary;
  logic accept;

  assign boundary = (cnt_q == CNT_MAX);
  assign accept   = sample_valid && !pend_full_q;

  // Frame buffering, boundary transfer/mute and underrun accounting.
  always_comb begin
    cnt_d       = cnt_q + 1'b1;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    act_d       = act_q;
    urun_d      = urun_q;
    if (accept) begin
      for (int k = 0; k < CHANNELS; k++) begin
        // Signed to offset-binary: flip the sign bit.
        pend_d[k] = sample_in[k*WIDTH +: WIDTH] ^ MIDSCALE;
      end
      pend_full_d = 1'b1;
    end
    if (boundary) begin
      if (mute) begin
        // Pending frame is kept so it plays once mute is released.
        for (int k = 0; k < CHANNELS; k++) begin
          act_d[k] = MIDSCALE;
        end
      end else if (pend_full_q) begin
        act_d       = pend_q;
        pend_full_d = 1'b0;
      end else if (urun_q != 16'hFFFF) begin
        // A same-cycle accept lands in pending, so this period is still an underrun.
        urun_d = urun_q + 16'd1;
      end
    end
  end

  // Per-channel modulator: PWM compare or sigma-delta carry.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      sum[k]   = {1'b0, acc_q[k]} + {1'b0, act_q[k]};
      acc_d[k] = sum[k][WIDTH-1:0];
      if (MODE == 1) begin
        dac_d[k] = sum[k][WIDTH];
      end else begin
        dac_d[k] = (cnt_q < act_q[k]);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      ready_q     <= 1'b1;
      urun_q      <= '0;
      fs_q        <= 1'b0;
      dac_q       <= '0;
      acc_q       <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        act_q[k] <= MIDSCALE;
      end
    end else begin
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      ready_q     <= !pend_full_d;
      urun_q      <= urun_d;
      fs_q        <= boundary;
      dac_q       <= dac_d;
      acc_q       <= acc_d;
      act_q       <= act_d;
    end
  end

  assign sample_ready   = ready_q;
  assign dac_out        = dac_q;
  assign frame_start    = fs_q;
  assign underrun_count = urun_q;

endmodule

// File: tb/tb_audio_dac_multi.sv
// Bench for audio_dac_multi: a PWM and a sigma-delta instance share one stimulus stream.
// Expected per-period ones counts are queued by the stimulus and checked by a frame_start-driven monitor.
module tb_audio_dac_multi;
  localparam int CH = 2;
  localparam int W  = 9;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [CH*W-1:0]   sample_in = '0;
  logic              sample_valid = 1'b0;
  logic              mute = 1'b0;

  logic              rdy_p, rdy_s, fs_p, fs_s;
  logic [CH-1:0]     dac_p, dac_s;
  logic [15:0]       ur_p, ur_s;

  audio_dac_multi #(.CHANNELS(CH), .WIDTH(W), .MODE(0)) dut_pwm (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(rdy_p), .mute(mute), .dac_out(dac_p), .frame_start(fs_p),
    .underrun_count(ur_p)
  );

  audio_dac_multi #(.CHANNELS(CH), .WIDTH(W), .MODE(1)) dut_sd (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(rdy_s), .mute(mute), .dac_out(dac_s), .frame_start(fs_s),
    .underrun_count(ur_s)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Scoreboard: expected ones-per-period for ch0/ch1 (same for both modes).
  typedef struct {
    int e0;
    int e1;
  } exp_t;
  exp_t sb[$];

  logic mon_en  = 1'b0;
  int   started = 0;
  int   pidx    = 1;
  int   pc0, pc1, sc0, sc1, len;

  // Window for a period runs from counter 1 through counter 0 of the next period (one-clock pin delay).
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (started != 0) begin
        pc0 += int'(dac_p[0]);
        pc1 += int'(dac_p[1]);
        sc0 += int'(dac_s[0]);
        sc1 += int'(dac_s[1]);
        len++;
      end
      if (fs_p) begin
        if (started != 0) begin
          if (sb.size() == 0) begin
            fail_now($sformatf("scoreboard_empty_p%0d", pidx));
          end else begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("period_len_p%0d", pidx), len, 512);
            check($sformatf("pwm_ch0_ones_p%0d", pidx), pc0, e.e0);
            check($sformatf("pwm_ch1_ones_p%0d", pidx), pc1, e.e1);
            check($sformatf("sd_ch0_ones_p%0d", pidx), sc0, e.e0);
            check($sformatf("sd_ch1_ones_p%0d", pidx), sc1, e.e1);
          end
          pidx++;
        end
        started = 1;
        pc0 = 0; pc1 = 0; sc0 = 0; sc1 = 0; len = 0;
      end
    end
  end

  // Offer a frame from a negedge; returns at the negedge after acceptance with valid still high.
  task automatic send(input logic [W-1:0] s0, input logic [W-1:0] s1,
                      output int waited, output logic fs_seen);
    sample_in    = {s1, s0};
    sample_valid = 1'b1;
    waited       = 0;
    while (!rdy_p && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    fs_seen = fs_p;
    if (!rdy_p) fail_now("send_timeout");
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_fs;
    int n;
    n = 0;
    @(negedge clk);
    while (!fs_p && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!fs_p) fail_now("wait_frame_start_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int   w;
    logic f;
    int   n;
    int   pwm_err;
    int   sd_err;
    logic prev;

    // Reset state, no clock edge yet.
    #1 rst_n = 1'b0;
    #2;
    check("rst_dac_pwm", dac_p, 0);
    check("rst_dac_sd", dac_s, 0);
    check("rst_ready", rdy_p, 1);
    check("rst_underrun", ur_p, 0);
    check("rst_frame_start", fs_p, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // F1: ch0=-256 -> u=0, ch1=255 -> u=511.
    send(9'h100, 9'h0FF, w, f);
    sample_valid = 1'b0;
    check("ready_low_after_accept", rdy_p, 0);

    n = 1;
    while (!fs_p && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("first_frame_start_cycle", n, 512);
    sb.push_back('{0, 511});                    // P1

    // Back-to-back F2 (midscale) and F3 with valid held high.
    send(9'h000, 9'h000, w, f);
    sb.push_back('{256, 256});                  // P2
    check("bp_ready_low", rdy_p, 0);
    send(9'h180, 9'h080, w, f);                 // u = 128, 384
    sb.push_back('{128, 384});                  // P3
    check("bp_accept_at_frame_start", f, 1);
    check("bp_wait_cycles", w, 511);
    sample_valid = 1'b0;

    // P2 waveform shape: PWM high for counter 0..255 (seen one clock later), sigma-delta alternates.
    pwm_err = 0;
    sd_err  = 0;
    prev    = 1'b0;
    for (int c = 1; c <= 512; c++) begin
      if (dac_p[0] !== ((c - 1) < 256)) pwm_err++;
      if (c > 1 && dac_s[0] === prev) sd_err++;
      prev = dac_s[0];
      @(negedge clk);
    end
    check("pwm_midscale_shape_errs", pwm_err, 0);
    check("sd_midscale_alternate_errs", sd_err, 0);

    // Underrun: three boundaries with no new frame, output held.
    check("underrun_before", ur_p, 0);
    sb.push_back('{128, 384});                  // P4
    sb.push_back('{128, 384});                  // P5
    sb.push_back('{128, 384});                  // P6
    wait_fs();
    check("underrun_after_1", ur_p, 1);
    wait_fs();
    wait_fs();
    check("underrun_after_3_pwm", ur_p, 3);
    check("underrun_after_3_sd", ur_s, 3);

    // Mute mid-period with a frame pending: takes effect at next boundary only.
    repeat (50) @(negedge clk);
    mute = 1'b1;
    send(9'h0FF, 9'h100, w, f);                 // u = 511, 0
    sample_valid = 1'b0;
    sb.push_back('{256, 256});                  // P7
    sb.push_back('{256, 256});                  // P8
    wait_fs();
    check("mute_pending_held_ready", rdy_p, 0);
    check("mute_no_underrun_1", ur_p, 3);
    wait_fs();
    check("mute_no_underrun_2", ur_p, 3);
    check("mute_ready_still_low", rdy_p, 0);
    mute = 1'b0;
    sb.push_back('{511, 0});                    // P9
    wait_fs();
    check("unmute_ready_back", rdy_p, 1);
    check("unmute_no_underrun", ur_p, 3);
    wait_fs();
    check("underrun_after_unmute", ur_p, 4);

    // Asynchronous reset mid-period with a frame pending.
    repeat (100) @(negedge clk);
    send(9'h010, 9'h020, w, f);
    sample_valid = 1'b0;
    check("pre_reset_ready_low", rdy_p, 0);
    check("pre_reset_pwm_high", dac_p[0], 1);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_dac_pwm", dac_p, 0);
    check("async_rst_dac_sd", dac_s, 0);
    check("async_rst_ready", rdy_p, 1);
    check("async_rst_underrun", ur_p, 0);
    check("async_rst_frame_start", fs_p, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", rdy_p, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
